countdown_timer: RTL and testbench

Loadable down-counter/timer. It is the consuming counterpart to the team's free-running up-counter: instead of counting up from reset, it accepts a start value over a valid/ready load interface and counts down to zero. It signals expiry with a one-cycle done pulse and supports one-shot and auto-reload (periodic) modes. It sits beside the up-counter in the timing utilities and drives timeouts and periodic ticks for downstream control logic.

---
 rtl/countdown_timer.sv | 114 +++++++++++
 tb/tb_countdown_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with a valid/ready load port, one-shot or periodic
// expiry, a registered one-cycle done pulse and a saturating expiry counter.
module countdown_timer #(
   parameter int WIDTH     = 8,
   parameter int EXP_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_load_valid,
   output logic                 o_load_ready,
   input  logic [WIDTH-1:0]     i_load_value,
   input  logic                 i_auto_reload,
   input  logic                 i_enable,
   input  logic                 i_abort,
   output logic [WIDTH-1:0]     o_count,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [EXP_WIDTH-1:0] o_expirations
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [WIDTH-1:0]     r_count;
   logic [WIDTH-1:0]     w_nextCount;
   logic [WIDTH-1:0]     r_reload;
   logic [WIDTH-1:0]     w_nextReload;
   logic                 r_autoReload;
   logic                 w_nextAutoReload;
   logic                 r_done;
   logic                 w_nextDone;
   logic [EXP_WIDTH-1:0] r_expirations;
   logic [EXP_WIDTH-1:0] w_nextExpirations;
   logic                 w_loadAccept;
   logic [EXP_WIDTH-1:0] w_expIncremented;

   assign o_load_ready  = (r_state == IDLE) && !i_abort;
   assign w_loadAccept  = i_load_valid && o_load_ready;
   assign o_count       = r_count;
   assign o_busy        = (r_state == RUN);
   assign o_done        = r_done;
   assign o_expirations = r_expirations;

   assign w_expIncremented = (r_expirations == '1) ? r_expirations
                                                   : r_expirations + EXP_WIDTH'(1);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= IDLE;
         r_count       <= '0;
         r_reload      <= '0;
         r_autoReload  <= 1'b0;
         r_done        <= 1'b0;
         r_expirations <= '0;
      end else begin
         r_state       <= w_nextState;
         r_count       <= w_nextCount;
         r_reload      <= w_nextReload;
         r_autoReload  <= w_nextAutoReload;
         r_done        <= w_nextDone;
         r_expirations <= w_nextExpirations;
      end
   end

   // Abort outranks both decrement and expiry; expiry happens at 1 so the count never wraps.
   always_comb begin
      w_nextState       = r_state;
      w_nextCount       = r_count;
      w_nextReload      = r_reload;
      w_nextAutoReload  = r_autoReload;
      w_nextDone        = 1'b0;
      w_nextExpirations = r_expirations;
      unique case (r_state)
         IDLE: begin
            if (w_loadAccept) begin
               w_nextCount       = i_load_value;
               w_nextReload      = i_load_value;
               w_nextAutoReload  = i_auto_reload;
               w_nextExpirations = '0;
               if (i_load_value != '0) begin
                  w_nextState = RUN;
               end else begin
                  w_nextDone        = 1'b1;
                  w_nextExpirations = EXP_WIDTH'(1);
               end
            end
         end
         RUN: begin
            if (i_abort) begin
               w_nextState = IDLE;
               w_nextCount = '0;
            end else if (i_enable) begin
               if (r_count == WIDTH'(1)) begin
                  w_nextDone        = 1'b1;
                  w_nextExpirations = w_expIncremented;
                  if (r_autoReload) begin
                     w_nextCount = r_reload;
                  end else begin
                     w_nextCount = '0;
                     w_nextState = IDLE;
                  end
               end else begin
                  w_nextCount = r_count - WIDTH'(1);
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table for the main scenarios plus
// hand-written sequences for expiry-counter saturation and asynchronous reset.
module tb_countdown_timer;

   localparam int WIDTH     = 8;
   localparam int EXP_WIDTH = 8;

   typedef struct {
      logic             valid;
      logic [WIDTH-1:0] value;
      logic             autoReload;
      logic             enable;
      logic             abort;
      logic             expReady;
      logic [WIDTH-1:0] expCount;
      logic             expBusy;
      logic             expDone;
      logic [7:0]       expExpirations;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 resetN;
   logic                 loadValid;
   logic                 loadReady;
   logic [WIDTH-1:0]     loadValue;
   logic                 autoReload;
   logic                 enable;
   logic                 abort;
   logic [WIDTH-1:0]     count;
   logic                 busy;
   logic                 done;
   logic [EXP_WIDTH-1:0] expirations;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   countdown_timer #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
      .i_clk         (clk),
      .i_reset_n     (resetN),
      .i_load_valid  (loadValid),
      .o_load_ready  (loadReady),
      .i_load_value  (loadValue),
      .i_auto_reload (autoReload),
      .i_enable      (enable),
      .i_abort       (abort),
      .o_count       (count),
      .o_busy        (busy),
      .o_done        (done),
      .o_expirations (expirations)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input int val, input logic ar, input logic en,
                               input logic ab, input logic rdy, input int cnt, input logic bsy,
                               input logic dn, input int ex);
      vec_t r;
      r.valid          = v;
      r.value          = WIDTH'(val);
      r.autoReload     = ar;
      r.enable         = en;
      r.abort          = ab;
      r.expReady       = rdy;
      r.expCount       = WIDTH'(cnt);
      r.expBusy        = bsy;
      r.expDone        = dn;
      r.expExpirations = 8'(ex);
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic driveInputs(input logic v, input int val, input logic ar, input logic en,
                              input logic ab);
      @(negedge clk);
      loadValid  = v;
      loadValue  = WIDTH'(val);
      autoReload = ar;
      enable     = en;
      abort      = ab;
   endtask

   task automatic driveCycle(input logic v, input int val, input logic ar, input logic en,
                             input logic ab);
      driveInputs(v, val, ar, en, ab);
      @(posedge clk);
      #1;
   endtask

   task automatic checkRegs(input string tag, input int cnt, input logic bsy, input logic dn,
                            input int ex);
      checkOutput({tag, " count"}, int'(count), cnt);
      checkOutput({tag, " busy"}, int'(busy), int'(bsy));
      checkOutput({tag, " done"}, int'(done), int'(dn));
      checkOutput({tag, " expirations"}, int'(expirations), ex);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      driveInputs(v.valid, int'(v.value), v.autoReload, v.enable, v.abort);
      #1;
      checkOutput({tag, " ready"}, int'(loadReady), int'(v.expReady));
      @(posedge clk);
      #1;
      checkRegs(tag, int'(v.expCount), v.expBusy, v.expDone, int'(v.expExpirations));
   endtask

   initial begin
      // One-shot load of 5
      vecs.push_back(mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
      // Auto-reload with period 3, then abort
      vecs.push_back(mk(1, 3, 1, 1, 0, 1, 3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1, 1, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1, 1, 3));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 3));
      // Enable gating: hold at 2 for three cycles
      vecs.push_back(mk(1, 4, 0, 1, 0, 1, 4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
      // Abort at count 1, then abort blocks a load while idle
      vecs.push_back(mk(1, 2, 0, 1, 0, 1, 2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      // Zero load pulses done without entering RUN
      vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1));

      resetN     = 1'b0;
      loadValid  = 1'b0;
      loadValue  = '0;
      autoReload = 1'b0;
      enable     = 1'b0;
      abort      = 1'b0;
      #3;
      checkRegs("reset", 0, 0, 0, 0);
      checkOutput("reset ready", int'(loadReady), 1);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
      end

      // Period-1 auto-reload: done every cycle, expiry counter sticks at 255
      driveCycle(1, 1, 1, 1, 0);
      checkRegs("sat load", 1, 1, 0, 0);
      for (int k = 1; k <= 300; k++) begin
         driveCycle(0, 0, 0, 1, 0);
         checkOutput($sformatf("sat%0d done", k), int'(done), 1);
         checkOutput($sformatf("sat%0d expirations", k), int'(expirations), (k > 255) ? 255 : k);
      end
      driveCycle(0, 0, 0, 1, 1);
      checkRegs("sat abort", 0, 0, 0, 255);

      // Asynchronous reset between edges in the middle of a long run
      driveCycle(1, 200, 0, 1, 0);
      checkRegs("long load", 200, 1, 0, 0);
      repeat (50) driveCycle(0, 0, 0, 1, 0);
      checkRegs("long mid", 150, 1, 0, 0);
      #2;
      resetN = 1'b0;
      #1;
      checkRegs("async reset", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      checkRegs("reset held", 0, 0, 0, 0);
      @(negedge clk);
      resetN = 1'b1;
      driveCycle(1, 2, 0, 1, 0);
      checkRegs("post reset load", 2, 1, 0, 0);
      driveCycle(0, 0, 0, 1, 0);
      checkRegs("post reset dec", 1, 1, 0, 0);
      driveCycle(0, 0, 0, 1, 0);
      checkRegs("post reset expire", 0, 0, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
